// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
// Holds the sequencer state encoding and the default operand width.
package div_pkg;

  localparam int unsigned DIV_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/subtractor.sv
// Combinational trial subtract for one restoring-division step.
// Produces the low N bits of P - M and a borrow flag (P < M).
module subtractor #(
  parameter int unsigned N = 8
) (
  input  logic [N:0]   P,
  input  logic [N-1:0] M,
  output logic [N-1:0] Diff,
  output logic         borrow
);

  // With no borrow the result is < M, so bit N of the difference is always zero.
  assign Diff   = P[N-1:0] - M;
  assign borrow = (P < {1'b0, M});

endmodule

// File: rtl/divider.sv
// Sequential restoring unsigned divider: 2N-bit dividend / N-bit divisor, one quotient bit per
// clock. AQ holds {remainder, quotient} when ready is high.
module divider
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] Din,
  input  logic [N-1:0]   Min,
  output logic           ready,
  output logic           err,
  output logic [2*N-1:0] AQ
);

  localparam int unsigned CW = $clog2(N) + 1;

  div_state_t       state_q, state_d;
  logic [2*N-1:0]   aq_q, aq_d;
  logic [N-1:0]     m_q, m_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  logic [N:0]       p;
  logic [N-1:0]     diff;
  logic             borrow;
  logic             overflow;

  assign p        = {aq_q[2*N-1:N], aq_q[N-1]};
  // Quotient would not fit in N bits; also catches a zero divisor.
  assign overflow = (Din[2*N-1:N] >= Min);

  subtractor #(
    .N(N)
  ) u_subtractor (
    .P     (p),
    .M     (m_q),
    .Diff  (diff),
    .borrow(borrow)
  );

  always_comb begin
    state_d = state_q;
    aq_d    = aq_q;
    m_d     = m_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = Min;
          count_d = '0;
          aq_d    = Din;
          if (overflow) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (borrow) begin
          aq_d = {aq_q[2*N-2:0], 1'b0};
        end else begin
          aq_d = {diff, aq_q[N-2:0], 1'b1};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      aq_q    <= '0;
      m_q     <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      aq_q    <= aq_d;
      m_q     <= m_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign ready = (state_q != CALC);
  assign err   = err_q;
  assign AQ    = aq_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: fixed vector table, hand-written handshake/reset sequences
// and random operands checked against plain integer division.
module tb_divider;

  localparam int N = 8;

  logic           clock;
  logic           reset;
  logic           start;
  logic [2*N-1:0] Din;
  logic [N-1:0]   Min;
  logic           ready;
  logic           err;
  logic [2*N-1:0] AQ;

  int n_cmp  = 0;
  int n_fail = 0;

  divider #(
    .N(N)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .Din  (Din),
    .Min  (Min),
    .ready(ready),
    .err  (err),
    .AQ   (AQ)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] din;
    logic [7:0]  min;
    logic [15:0] exp_aq;
    logic        exp_err;
    int          exp_cycles;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with the entry overflow rule.
  task automatic model(input logic [15:0] din, input logic [7:0] min,
                       output logic [15:0] exp_aq, output logic exp_err, output int exp_cyc);
    int unsigned q, r;
    if (int'(din >> 8) >= int'(min)) begin
      exp_aq  = din;
      exp_err = 1'b1;
      exp_cyc = 0;
    end else begin
      q       = int'(din) / int'(min);
      r       = int'(din) % int'(min);
      exp_aq  = {r[7:0], q[7:0]};
      exp_err = 1'b0;
      exp_cyc = N;
    end
  endtask

  // Accept one operation, scramble inputs afterwards, count busy cycles (bounded).
  task automatic do_div(input logic [15:0] din, input logic [7:0] min, output int cycles);
    @(negedge clock);
    start = 1'b1;
    Din   = din;
    Min   = min;
    @(posedge clock);
    #1;
    start  = 1'b0;
    Din    = 16'($urandom);
    Min    = 8'($urandom);
    cycles = 0;
    while (!ready && cycles < 50) begin
      @(posedge clock);
      #1;
      cycles++;
    end
  endtask

  task automatic run_check(input string name, input logic [15:0] din, input logic [7:0] min);
    logic [15:0] eaq;
    logic        eerr;
    int          ecyc, cyc;
    model(din, min, eaq, eerr, ecyc);
    do_div(din, min, cyc);
    check({name, ".cycles"}, cyc, ecyc);
    check({name, ".aq"}, AQ, eaq);
    check({name, ".err"}, err, eerr);
  endtask

  vec_t vecs[6];

  initial begin
    int cyc;
    logic [15:0] d;
    logic [7:0]  m;

    vecs[0] = '{16'd100,  8'd7,    16'h020E, 1'b0, 8};
    vecs[1] = '{16'hFEFF, 8'hFF,   16'hFEFF, 1'b0, 8};
    vecs[2] = '{16'h1234, 8'd0,    16'h1234, 1'b1, 0};
    vecs[3] = '{16'h0300, 8'd3,    16'h0300, 1'b1, 0};
    vecs[4] = '{16'd200,  8'd9,    16'h0216, 1'b0, 8};
    vecs[5] = '{16'd0,    8'd1,    16'h0000, 1'b0, 8};

    start = 1'b1;
    reset = 1'b1;
    Din   = 16'd100;
    Min   = 8'd7;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset.ready", ready, 1'b1);
    check("reset.aq", AQ, 16'h0);
    check("reset.err", err, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clock);
    #1;
    check("reset.no_accept", ready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      do_div(vecs[i].din, vecs[i].min, cyc);
      check($sformatf("vec%0d.cycles", i), cyc, vecs[i].exp_cycles);
      check($sformatf("vec%0d.aq", i), AQ, vecs[i].exp_aq);
      check($sformatf("vec%0d.err", i), err, vecs[i].exp_err);
    end

    // Reset on the 4th CALC edge.
    @(negedge clock);
    start = 1'b1;
    Din   = 16'd100;
    Min   = 8'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("midreset.busy", ready, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midreset.ready", ready, 1'b1);
    check("midreset.aq", AQ, 16'h0);
    @(negedge clock);
    reset = 1'b0;
    run_check("after_reset", 16'd200, 8'd9);

    // start pulsed during CALC is ignored.
    @(negedge clock);
    start = 1'b1;
    Din   = 16'd100;
    Min   = 8'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    start = 1'b1;
    Din   = 16'd50;
    Min   = 8'd3;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (!ready && cyc < 50) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("calc_start.aq", AQ, 16'h020E);
    check("calc_start.err", err, 1'b0);

    // start held through DONE: error result, then re-accept clears err.
    @(negedge clock);
    start = 1'b1;
    Din   = 16'h1234;
    Min   = 8'd0;
    @(posedge clock);
    #1;
    check("b2b.err_set", err, 1'b1);
    check("b2b.err_aq", AQ, 16'h1234);
    check("b2b.err_ready", ready, 1'b1);
    Din = 16'd1000;
    Min = 8'd10;
    @(posedge clock);
    #1;
    check("b2b.reaccept", ready, 1'b0);
    check("b2b.err_clear", err, 1'b0);
    // Next op queued on the held start: result visible for exactly one cycle.
    Din = 16'd77;
    Min = 8'd5;
    cyc = 0;
    while (!ready && cyc < 50) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("b2b.cycles", cyc, N);
    check("b2b.aq", AQ, {8'd0, 8'd100});
    @(posedge clock);
    #1;
    check("b2b.one_cycle", ready, 1'b0);
    start = 1'b0;
    cyc = 0;
    while (!ready && cyc < 50) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("b2b2.aq", AQ, {8'd2, 8'd15});

    for (int i = 0; i < 150; i++) begin
      m = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin
        d = 16'($urandom);
      end else if (m == 8'd0) begin
        d = 16'($urandom);
      end else begin
        d = {8'($urandom_range(0, int'(m) - 1)), 8'($urandom)};
      end
      run_check($sformatf("rand%0d", i), d, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divider.md
# divider

Sequential shift-and-subtract (restoring) unsigned divider: a 2N-bit dividend divided by an N-bit divisor gives an N-bit quotient and an N-bit remainder, one quotient bit per clock. It is the inverse datapath of the shift-and-add multiplier and shares its style:
- a combined `AQ` accumulator/quotient register;
- a divisor register `M`;
- a small sequencer with a `start`/`ready` handshake.

## Interface
- `N`, default 8: divisor, quotient and remainder width; the dividend is 2N bits.
- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a division; sampled only while `ready`=1.
- `Din`, input, 2N: dividend; sampled on the accepting edge only.
- `Min`, input, N: divisor; sampled on the accepting edge only.
- `ready`, output, 1: high when idle or done; the block accepts `start` and `AQ` is valid.
- `err`, output, 1: the last accepted operation overflowed or divided by zero.
- `AQ`, output, 2N: result. `AQ[2N-1:N]` is the remainder and `AQ[N-1:0]` is the quotient.

## Operation
- **Registers:** `AQ` (2N bits), `M` (N bits), `count` ($clog2(N)+1 bits), state, `err`.
- **States:** IDLE, CALC, DONE. `ready` = (state != CALC).
- **Reset** (synchronous, overrides everything, including mid-CALC):
  - state=IDLE, `AQ`=0, `M`=0, `count`=0, `err`=0;
  - so `ready`=1.
- **Accept:** in IDLE or DONE with `start`=1:
  - `M` <= `Min`, `count` <= 0.
  - If `Din[2N-1:N]` >= `Min` (overflow; this covers `Min`=0): `AQ` <= `Din` unchanged, `err` <= 1, state <= DONE.
  - Otherwise: `AQ` <= `Din`, `err` <= 0, state <= CALC.
- **CALC step:** one per edge.
  - P = {`AQ[2N-1:N]`, `AQ[N-1]`}, (N+1) bits.
  - D = P − {1'b0, `M`}, (N+1)-bit subtract with borrow.
  - If no borrow: `AQ` <= {D[N-1:0], `AQ[N-2:0]`, 1'b1}.
  - If borrow: `AQ` <= {`AQ[2N-2:0]`, 1'b0}.
  - `count` <= `count`+1. After the step with `count`=N−1, state <= DONE.
- **Remainder bound:** the entry check guarantees remainder < `M` at every step. D[N] is therefore redundant when there is no borrow, and the remainder never needs N+1 bits.
- **DONE:** `AQ` and `err` hold until the next acceptance or reset.
- **`start` while CALC:** ignored; it is not queued.
- **`Din`/`Min` changes** after the accepting edge have no effect.

## Timing
- **Normal division:**
  - `ready` falls after the accepting edge E0.
  - Steps occur on edges E1..EN.
  - `ready`=1 and the result is valid after EN, so the unit is busy for exactly N cycles (8 for N=8).
- **Error path:** `ready` never falls. `err`=1 and `AQ`=`Din` are visible after E0 (1 cycle).
- **Back-to-back:** `start` held high through DONE is re-accepted on the first DONE edge. The result is visible for exactly one cycle before being overwritten.
- **Outputs:** all are registered or decoded directly from state; no combinational path from inputs to outputs.

## Structure
- **Package `div_pkg`:** state enum typedef `div_state_t` (IDLE, CALC, DONE) and default width constant `DIV_N`=8.
- **Sub-module `subtractor`:** the counterpart of the multiplier's adder.
  - Inputs: P (N+1 bits) and M (N bits).
  - Outputs: Diff (N bits) and `borrow`.
  - Purely combinational.
- **Top level:** the sequencer FSM and the `AQ`/`M` registers live in `divider`.

## Test plan
1. **Reset:** assert `reset` 2 cycles, with `start`=1 during reset → `ready`=1, `AQ`=0, `err`=0; no operation accepted.
2. **Basic division:** `Din`=16'd100, `Min`=8'd7, pulse `start` → `ready`=0 for 8 cycles, then `AQ[7:0]`=14, `AQ[15:8]`=2, `err`=0.
3. **Max valid:** `Din`=16'hFEFF, `Min`=8'hFF → quotient 8'hFF, remainder 8'hFE after 8 cycles.
4. **Errors:**
   - `Min`=0, `Din`=16'h1234 → after 1 edge `err`=1, `ready`=1, `AQ`=16'h1234.
   - Repeat with `Din`=16'h0300, `Min`=3 → `err`=1.
5. **Reset mid-operation:** start 100/7, assert `reset` on the 4th CALC edge → next cycle `ready`=1, `AQ`=0. A following start of 200/9 yields quotient 22, remainder 2.
6. **Handshake:**
   - `start` pulsed during CALC is ignored (result still 14 r 2).
   - `start` held high across DONE → 1 cycle of result, then the new operation begins, and `err` clears on that acceptance.
